// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: deframer states and mouse packet geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int PS2_PKT_LEN  = 3;
    localparam int PS2_SYNC_BIT = 3;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_framer_if.sv
// Result bundle produced by the PS/2 framer and consumed by the mouse buffer / interrupt logic.
interface ps2_rx_framer_if;
    logic [31:0] oHistory;
    logic [7:0]  oByte;
    logic        oByteValid;
    logic        oPacketValid;
    logic        oParityErr;
    logic        oFrameErr;
    logic        oBusy;

    modport master (
        output oHistory, oByte, oByteValid, oPacketValid, oParityErr, oFrameErr, oBusy
    );

    modport slave (
        input  oHistory, oByte, oByteValid, oPacketValid, oParityErr, oFrameErr, oBusy
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a deglitcher that only changes level after
// FILTER_LEN consecutive samples disagree with the current filtered level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] run_cnt;

    // Idle PS/2 lines float high, so everything starts at 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            level   <= 1'b1;
            run_cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_framer.sv
// Deframes PS/2 device-to-host frames into validated bytes, keeps a 4-byte history
// and tracks 3-byte mouse packet alignment.
module ps2_rx_framer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic iCLK,
    input  logic Reset,
    input  logic iPS2_CLK,
    input  logic iPS2_DAT,
    ps2_rx_framer_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_filt;
    logic          dat_filt;
    logic          clk_prev;
    logic          fall;

    ps2_state_e    state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] idle_cnt;
    logic [1:0]    pkt_idx;

    logic [31:0]   history;
    logic [7:0]    byte_r;
    logic          byte_valid;
    logic          packet_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (iCLK),
        .rst   (Reset),
        .raw   (iPS2_CLK),
        .level (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk   (iCLK),
        .rst   (Reset),
        .raw   (iPS2_DAT),
        .level (dat_filt)
    );

    assign fall = clk_prev & ~clk_filt;

    // Deframer, timeout watchdog and packet tracker share one register block so every
    // pulse output is registered and lands in the cycle after the deciding clock fall.
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            clk_prev     <= 1'b1;
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            par_bit      <= 1'b0;
            idle_cnt     <= '0;
            pkt_idx      <= '0;
            history      <= '0;
            byte_r       <= '0;
            byte_valid   <= 1'b0;
            packet_valid <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            clk_prev     <= clk_filt;
            byte_valid   <= 1'b0;
            packet_valid <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;

            if (state == IDLE || fall) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_filt, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_filt;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!dat_filt) begin
                            frame_err <= 1'b1;
                            pkt_idx   <= '0;
                        end else if (!odd_parity_ok(shift, par_bit)) begin
                            parity_err <= 1'b1;
                            pkt_idx    <= '0;
                        end else begin
                            byte_valid <= 1'b1;
                            byte_r     <= shift;
                            history    <= {history[23:0], shift};
                            // Only a byte with the always-one header bit may open a packet.
                            if (pkt_idx == 2'd0) begin
                                pkt_idx <= shift[PS2_SYNC_BIT] ? 2'd1 : 2'd0;
                            end else if (pkt_idx == 2'(PS2_PKT_LEN - 1)) begin
                                packet_valid <= 1'b1;
                                pkt_idx      <= '0;
                            end else begin
                                pkt_idx <= pkt_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state != IDLE && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                pkt_idx   <= '0;
            end
        end
    end

    assign bus.oHistory     = history;
    assign bus.oByte        = byte_r;
    assign bus.oByteValid   = byte_valid;
    assign bus.oPacketValid = packet_valid;
    assign bus.oParityErr   = parity_err;
    assign bus.oFrameErr    = frame_err;
    assign bus.oBusy        = busy;

endmodule
